// File: rtl/phase_error_lut.sv
// phase_error_lut: phase error / angle lookup table with a two-stage read
// pipeline and a streaming reload port.
// Table words are {phi_error, val_engle}. The table is addressed by
// {phase_acum_mod, input_angles}.
// Optional feature macro PHASE_LUT_SYMFOLD_EN: store only the lower half of
// the accumulator range. The upper half is read through the mirrored address,
// and phi_error is negated on the way out.
module phase_error_lut #(
   parameter int ANGLE_W   = 9,
   parameter int ACC_W     = 9,
   parameter int ERR_W     = 9,
   parameter int VAL_W     = 10,
   parameter int CH_W      = 2,
   parameter     INIT_FILE = "mem.mif"
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CH_W-1:0]          in_ch,
   input  logic [ANGLE_W-1:0]       input_angles,
   input  logic [ACC_W-1:0]         phase_acum_mod,
   output logic                     out_valid,
   output logic [CH_W-1:0]          out_ch,
   output logic [ERR_W-1:0]         phi_error,
   output logic [VAL_W-1:0]         val_engle,
   input  logic                     load_start,
   input  logic                     ld_valid,
   input  logic [ERR_W+VAL_W-1:0]   ld_data,
   output logic                     ld_done
);

   localparam int W = ERR_W + VAL_W;
`ifdef PHASE_LUT_SYMFOLD_EN
   localparam int MEM_AW = ACC_W + ANGLE_W - 1;
`else
   localparam int MEM_AW = ACC_W + ANGLE_W;
`endif
   // LOAD_LEN equals the stored depth in both builds.
   localparam int MEM_DEPTH = 2 ** MEM_AW;

   typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_t;

   state_t              state_q;
   logic [MEM_AW-1:0]   cnt_q;
   logic                ld_done_q;

   logic                v1_q;
   logic [MEM_AW-1:0]   addr1_q;
   logic [CH_W-1:0]     ch1_q;
   logic                neg1_q;

   logic                out_valid_q;
   logic [CH_W-1:0]     out_ch_q;
   logic [ERR_W-1:0]    phi_q;
   logic [VAL_W-1:0]    val_q;

   logic [MEM_AW-1:0]   addr_d;
   logic                neg_d;
   logic                accept;
   logic [W-1:0]        rd_word;
   logic [ERR_W-1:0]    rd_phi;
   logic [ERR_W-1:0]    phi_d;

   (* ram_init_file = INIT_FILE *) logic [W-1:0] mem_q [MEM_DEPTH];

   assign in_ready  = (state_q == RUN);
   assign accept    = in_valid && (state_q == RUN);
   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign phi_error = phi_q;
   assign val_engle = val_q;
   assign ld_done   = ld_done_q;

   // Request address formation (mirrored upper half when folding).
   always_comb begin
`ifdef PHASE_LUT_SYMFOLD_EN
      addr_d = {phase_acum_mod[ACC_W-2:0] ^ {(ACC_W-1){phase_acum_mod[ACC_W-1]}},
                input_angles};
      neg_d  = phase_acum_mod[ACC_W-1];
`else
      addr_d = {phase_acum_mod, input_angles};
      neg_d  = 1'b0;
`endif
   end

   // Table read for stage 2 and optional phi negation (wraps modulo 2^ERR_W).
   always_comb begin
      rd_word = mem_q[addr1_q];
      rd_phi  = rd_word[W-1:VAL_W];
      phi_d   = neg1_q ? ('0 - rd_phi) : rd_phi;
   end

   // Stage 1: capture address, tag and fold flag of an accepted request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1_q    <= 1'b0;
         addr1_q <= '0;
         ch1_q   <= '0;
         neg1_q  <= 1'b0;
      end else begin
         v1_q <= accept;
         if (accept) begin
            addr1_q <= addr_d;
            ch1_q   <= in_ch;
            neg1_q  <= neg_d;
         end
      end
   end

   // Stage 2: register table word and tag; outputs hold while idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         phi_q       <= '0;
         val_q       <= '0;
      end else begin
         out_valid_q <= v1_q;
         if (v1_q) begin
            out_ch_q <= ch1_q;
            phi_q    <= phi_d;
            val_q    <= rd_word[VAL_W-1:0];
         end
      end
   end

   // RUN/LOAD control, load counter and ld_done pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= RUN;
         cnt_q     <= '0;
         ld_done_q <= 1'b0;
      end else begin
         ld_done_q <= 1'b0;
         case (state_q)
            RUN: begin
               if (load_start) state_q <= LOAD;
            end
            LOAD: begin
               if (ld_valid) begin
                  if (cnt_q == '1) begin
                     cnt_q     <= '0;
                     ld_done_q <= 1'b1;
                     state_q   <= RUN;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

   // Table write port; a same-cycle read of this word still sees the old value.
   always_ff @(posedge clk) begin
      if (state_q == LOAD && ld_valid) mem_q[cnt_q] <= ld_data;
   end

endmodule

// File: tb/tb_phase_error_lut.sv
// Self-checking bench for phase_error_lut (small table geometry).
module tb_phase_error_lut;

   localparam int ANGLE_W = 4;
   localparam int ACC_W   = 4;
   localparam int ERR_W   = 9;
   localparam int VAL_W   = 10;
   localparam int CH_W    = 2;
   localparam int W       = ERR_W + VAL_W;
   localparam int NLOG    = 1 << (ACC_W + ANGLE_W);
`ifdef PHASE_LUT_SYMFOLD_EN
   localparam int LOAD_LEN = NLOG / 2;
`else
   localparam int LOAD_LEN = NLOG;
`endif

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [CH_W-1:0]      in_ch = '0;
   logic [ANGLE_W-1:0]   input_angles = '0;
   logic [ACC_W-1:0]     phase_acum_mod = '0;
   logic                 out_valid;
   logic [CH_W-1:0]      out_ch;
   logic [ERR_W-1:0]     phi_error;
   logic [VAL_W-1:0]     val_engle;
   logic                 load_start = 1'b0;
   logic                 ld_valid = 1'b0;
   logic [W-1:0]         ld_data = '0;
   logic                 ld_done;

   phase_error_lut #(
      .ANGLE_W   (ANGLE_W),
      .ACC_W     (ACC_W),
      .ERR_W     (ERR_W),
      .VAL_W     (VAL_W),
      .CH_W      (CH_W),
      .INIT_FILE ("mem.mif")
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_ch          (in_ch),
      .input_angles   (input_angles),
      .phase_acum_mod (phase_acum_mod),
      .out_valid      (out_valid),
      .out_ch         (out_ch),
      .phi_error      (phi_error),
      .val_engle      (val_engle),
      .load_start     (load_start),
      .ld_valid       (ld_valid),
      .ld_data        (ld_data),
      .ld_done        (ld_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit              v;
      logic [W-1:0]    w;
      logic [CH_W-1:0] ch;
   } exp_t;

   logic [W-1:0]    stored [LOAD_LEN];
   logic [W-1:0]    nt     [LOAD_LEN];
   logic [W-1:0]    last_w  = '0;
   logic [CH_W-1:0] last_ch = '0;
   int tests = 0;
   int fails = 0;

   // Expected output word for a lookup, from the stored-table model.
   function automatic logic [W-1:0] ref_lookup(input int acc, input int ang);
      logic [W-1:0] w;
`ifdef PHASE_LUT_SYMFOLD_EN
      int half;
      int phi;
      half = 1 << (ACC_W - 1);
      if (acc >= half) begin
         w   = stored[(2 * half - 1 - acc) * (1 << ANGLE_W) + ang];
         phi = ((1 << ERR_W) - int'(w[W-1:VAL_W])) % (1 << ERR_W);
         w[W-1:VAL_W] = ERR_W'(phi);
      end else begin
         w = stored[acc * (1 << ANGLE_W) + ang];
      end
`else
      w = stored[acc * (1 << ANGLE_W) + ang];
`endif
      return w;
   endfunction

   // Drives reload words first..stop-1 with a gap every third cycle and
   // reports what it observed; the caller does the comparisons.
   task automatic load_body(input int first, input int stop,
                            output int done_cnt, output int bad, output bit done_last);
      int idx;
      int c;
      idx = first;
      c = 0;
      done_cnt = 0;
      bad = 0;
      done_last = 1'b0;
      while (idx < stop) begin
         bit last_now;
         in_valid       = ($urandom % 2) == 1;
         input_angles   = ANGLE_W'($urandom);
         phase_acum_mod = ACC_W'($urandom);
         in_ch          = CH_W'($urandom);
         if (c % 3 == 2) begin
            ld_valid   = 1'b0;
            load_start = 1'b1;
            ld_data    = W'($urandom);
            last_now   = 1'b0;
         end else begin
            ld_valid    = 1'b1;
            load_start  = 1'b0;
            ld_data     = nt[idx];
            stored[idx] = nt[idx];
            last_now    = (idx == LOAD_LEN - 1);
            idx++;
         end
         c++;
         @(posedge clk); #1;
         if (last_now) done_last = ld_done;
         else begin
            if (ld_done) done_cnt++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
         end
      end
      ld_valid   = 1'b0;
      load_start = 1'b0;
      in_valid   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      tests++; if (ld_done !== 1'b0) begin fails++; $display("FAIL reset_ld_done: got %b expected 0", ld_done); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      tests++; if ({phi_error, val_engle, out_ch} !== '0) begin fails++;
         $display("FAIL reset_outputs: got %h/%h/%h expected 0/0/0", phi_error, val_engle, out_ch); end
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      last_w = '0;
      last_ch = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_reload();
      int dc, bad;
      bit dl;
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reload_enter: in_ready got %b expected 0", in_ready); end
      load_body(0, LOAD_LEN, dc, bad, dl);
      tests++; if (dl !== 1'b1) begin fails++; $display("FAIL reload_done_pulse: got %b expected 1", dl); end
      tests++; if (dc != 0) begin fails++; $display("FAIL reload_done_extra: got %0d pulses expected 0", dc); end
      tests++; if (bad != 0) begin fails++; $display("FAIL reload_busy: got %0d bad cycles expected 0", bad); end
      @(posedge clk); #1;
      tests++; if (ld_done !== 1'b0) begin fails++; $display("FAIL reload_done_width: got %b expected 0", ld_done); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reload_ready_after: got %b expected 1", in_ready); end
   endtask

   // mode 0: full readback, 1: four back-to-back tags 0..3, 2: random traffic
   task automatic test_lookups(input int mode);
      exp_t q[$];
      exp_t e;
      int n;
      n = (mode == 0) ? NLOG : ((mode == 1) ? 4 : 300);
      for (int j = 0; j < n + 2; j++) begin
         int acc, ang;
         bit v;
         if (q.size() == 2) begin
            e = q.pop_front();
            tests++;
            if (out_valid !== e.v) begin fails++;
               $display("FAIL lookup_valid_m%0d_%0d: got %b expected %b", mode, j, out_valid, e.v); end
            if (e.v) begin last_w = e.w; last_ch = e.ch; end
            tests++;
            if ({phi_error, val_engle} !== last_w || out_ch !== last_ch) begin fails++;
               $display("FAIL lookup_data_m%0d_%0d: got %h/%h ch %0d expected %h/%h ch %0d", mode, j,
                        phi_error, val_engle, out_ch, last_w[W-1:VAL_W], last_w[VAL_W-1:0], last_ch); end
         end
         if (j < n) begin
            v = (mode == 2) ? (($urandom % 10) < 7) : 1'b1;
            if (mode == 0) begin acc = j >> ANGLE_W; ang = j % (1 << ANGLE_W); end
            else begin acc = $urandom % (1 << ACC_W); ang = $urandom % (1 << ANGLE_W); end
            e.ch = (mode == 1) ? CH_W'(j) : CH_W'($urandom);
         end else begin
            v = 1'b0; acc = 0; ang = 0; e.ch = '0;
         end
         in_valid       = v;
         phase_acum_mod = ACC_W'(acc);
         input_angles   = ANGLE_W'(ang);
         in_ch          = e.ch;
         e.v = v;
         e.w = ref_lookup(acc, ang);
         q.push_back(e);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_directed();
      in_valid = 1'b1; phase_acum_mod = ACC_W'(3); input_angles = ANGLE_W'(5); in_ch = 2'd2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL directed_early: got %b expected 0", out_valid); end
      @(posedge clk); #1;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL directed_valid: got %b expected 1", out_valid); end
      tests++; if (phi_error !== 9'h012 || val_engle !== 10'h155 || out_ch !== 2'd2) begin fails++;
         $display("FAIL directed_data: got %h/%h ch %0d expected 012/155 ch 2", phi_error, val_engle, out_ch); end
      @(posedge clk); #1;
      tests++; if (out_valid !== 1'b0 || phi_error !== 9'h012 || val_engle !== 10'h155 || out_ch !== 2'd2) begin fails++;
         $display("FAIL directed_hold: got v=%b %h/%h ch %0d expected v=0 012/155 ch 2", out_valid, phi_error, val_engle, out_ch); end
      last_w = {9'h012, 10'h155};
      last_ch = 2'd2;
   endtask

`ifdef PHASE_LUT_SYMFOLD_EN
   task automatic test_fold();
      logic [VAL_W-1:0] ev;
      ev = stored[(1 << ANGLE_W) + 7][VAL_W-1:0];
      in_valid = 1'b1; phase_acum_mod = ACC_W'((1 << ACC_W) - 2); input_angles = ANGLE_W'(7); in_ch = 2'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      tests++; if (out_valid !== 1'b1 || phi_error !== 9'h1F0 || val_engle !== ev) begin fails++;
         $display("FAIL fold_negate: got v=%b %h/%h expected v=1 1f0/%h", out_valid, phi_error, val_engle, ev); end
      last_w = {9'h1F0, ev};
      last_ch = 2'd3;
      @(posedge clk); #1;
   endtask
`endif

   task automatic test_collision();
      logic [W-1:0] old;
      int dc, bad;
      bit dl;
      for (int i = 0; i < LOAD_LEN; i++) nt[i] = W'($urandom);
      old = ref_lookup(0, 0);
      nt[0] = ~stored[0];
      in_valid = 1'b1; phase_acum_mod = '0; input_angles = '0; in_ch = 2'd1; load_start = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; load_start = 1'b0;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL collision_load_entered: got %b expected 0", in_ready); end
      ld_valid = 1'b1; ld_data = nt[0]; stored[0] = nt[0];
      @(posedge clk); #1;
      tests++; if (out_valid !== 1'b1 || {phi_error, val_engle} !== old || out_ch !== 2'd1) begin fails++;
         $display("FAIL collision_old_data: got v=%b %h/%h ch %0d expected v=1 %h/%h ch 1", out_valid,
                  phi_error, val_engle, out_ch, old[W-1:VAL_W], old[VAL_W-1:0]); end
      last_w = old;
      last_ch = 2'd1;
      load_body(1, LOAD_LEN, dc, bad, dl);
      tests++; if (dl !== 1'b1 || dc != 0 || bad != 0) begin fails++;
         $display("FAIL collision_load: got done=%b extra=%0d bad=%0d expected 1/0/0", dl, dc, bad); end
      @(posedge clk); #1;
      tests++; if (ld_done !== 1'b0 || in_ready !== 1'b1) begin fails++;
         $display("FAIL collision_after: got ld_done=%b in_ready=%b expected 0/1", ld_done, in_ready); end
   endtask

   task automatic test_reset_during_load();
      int dc, bad, late;
      bit dl;
      for (int i = 0; i < LOAD_LEN; i++) nt[i] = stored[i] ^ W'(1 + $urandom_range(0, (1 << W) - 2));
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
      load_body(0, 100, dc, bad, dl);
      tests++; if (dc != 0 || bad != 0) begin fails++;
         $display("FAIL partial_load: got extra=%0d bad=%0d expected 0/0", dc, bad); end
      ld_valid = 1'b1; ld_data = nt[100];
      #1 reset = 1'b1;
      #1;
      tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || ld_done !== 1'b0) begin fails++;
         $display("FAIL reset_in_load: got v=%b rdy=%b done=%b expected 0/1/0", out_valid, in_ready, ld_done); end
      tests++; if ({phi_error, val_engle, out_ch} !== '0) begin fails++;
         $display("FAIL reset_in_load_out: got %h/%h/%h expected 0/0/0", phi_error, val_engle, out_ch); end
      last_w = '0;
      last_ch = '0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      late = 0;
      for (int k = 0; k < 3; k++) begin
         ld_data = nt[101 + k];
         @(posedge clk); #1;
         if (ld_done !== 1'b0 || in_ready !== 1'b1) late++;
      end
      ld_valid = 1'b0;
      tests++; if (late != 0) begin fails++; $display("FAIL run_ignores_ld_valid: got %0d bad cycles expected 0", late); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < LOAD_LEN; i++) begin
         nt[i] = W'($urandom);
         stored[i] = '0;
      end
      nt[(3 << ANGLE_W) + 5] = {9'h012, 10'h155};
`ifdef PHASE_LUT_SYMFOLD_EN
      nt[(1 << ANGLE_W) + 7] = {9'h010, VAL_W'($urandom)};
`endif
      test_reset();
      test_reload();
      test_lookups(0);
      test_directed();
`ifdef PHASE_LUT_SYMFOLD_EN
      test_fold();
`endif
      test_lookups(1);
      test_lookups(2);
      test_collision();
      test_lookups(0);
      test_reset_during_load();
      test_lookups(0);
      test_lookups(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/phase_error_lut.md
PHASE_ERROR_LUT -- requirements
Module: phase_error_lut

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ANGLE_W, 9, input angle width
- ACC_W, 9, phase accumulator width
- ERR_W, 9, phase error width
- VAL_W, 10, angle value width
- CH_W, 2, channel tag width
- INIT_FILE, "mem.mif", table init file
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock
- reset, in, 1, asynchronous active-high reset
- in_valid, in, 1, lookup request
- in_ready, out, 1, lookup accepted when high with in_valid
- in_ch, in, CH_W, channel tag
- input_angles, in, ANGLE_W, angle index
- phase_acum_mod, in, ACC_W, accumulator index
- out_valid, out, 1, result valid
- out_ch, out, CH_W, echoed channel tag
- phi_error, out, ERR_W, phase error (two's complement)
- val_engle, out, VAL_W, angle value
- load_start, in, 1, start table reload
- ld_valid, in, 1, reload word strobe
- ld_data, in, ERR_W+VAL_W, reload word {phi_error, val_engle}
- ld_done, out, 1, one-cycle pulse after the last reload word
REQ-003 The design SHALL use one clock, clk; reset SHALL be asynchronous and active-high.

Function
REQ-004 Table depth SHALL be DEPTH = 2^(ACC_W+ANGLE_W) words of ERR_W+VAL_W bits; the address SHALL be {phase_acum_mod, input_angles}; contents SHALL be preloaded from INIT_FILE.
REQ-005 States SHALL be RUN and LOAD.
- in_ready = 1 in RUN, 0 in LOAD.
REQ-006 Lookup pipeline:
- Stage 1 registers the address, tag and valid on an accepted request.
- Stage 2 registers the RAM read into {phi_error, val_engle}, plus out_ch and out_valid.
- Latency is exactly 2 cycles from acceptance to out_valid.
- Throughput is one lookup per cycle; requests carrying different tags SHALL not interact.
REQ-007 The outputs phi_error, val_engle and out_ch SHALL hold their last values while out_valid is 0.
REQ-008 RUN to LOAD: on load_start in RUN. A lookup accepted in the same cycle SHALL complete with pre-load contents.
REQ-009 In LOAD, each ld_valid SHALL write ld_data at the load counter and then increment the counter; the counter SHALL start at 0.
REQ-010 When the write at address DEPTH-1 (LOAD_LEN-1 under folding) occurs, the block SHALL:
- pulse ld_done for the next cycle,
- clear the counter,
- return to RUN on the next cycle.
REQ-011 load_start SHALL be ignored while in LOAD; cycles with ld_valid low SHALL neither write nor advance the counter.
REQ-012 Lookups in flight when LOAD is entered SHALL drain normally.
- Any read of an address written in the same cycle SHALL return the old data.
REQ-013 ld_valid SHALL be ignored in RUN.

Reset
REQ-014 On reset assertion the block SHALL immediately force:
- state = RUN, load counter = 0;
- out_valid = 0, ld_done = 0;
- phi_error = 0, val_engle = 0, out_ch = 0;
- pipeline valid bits cleared.
REQ-015 Table contents SHALL NOT be affected by reset; a reset during LOAD SHALL keep the partially written words and abandon the load without a ld_done pulse.

Configuration
REQ-016 With macro PHASE_LUT_SYMFOLD_EN defined, the block SHALL store only half the table:
- Depth = DEPTH/2 and LOAD_LEN = DEPTH/2.
- Read address = {phase_acum_mod[ACC_W-2:0] XOR replicated phase_acum_mod[ACC_W-1], input_angles}.
- When phase_acum_mod[ACC_W-1] = 1, the output phi_error SHALL be the two's-complement negation of the stored value, with wrap (most negative value maps to itself); val_engle is unchanged.
- Latency SHALL remain 2.
REQ-017 Without PHASE_LUT_SYMFOLD_EN, the block SHALL use the full table, direct addressing and LOAD_LEN = DEPTH.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Directed lookup: table word at {acc=3, ang=5} = {9'h012, 10'h155}; in_valid at cycle 0 with in_ch=2 -> out_valid at cycle 2 with phi_error=9'h012, val_engle=10'h155, out_ch=2.
- Back-to-back: 4 consecutive requests with tags 0..3 -> 4 consecutive out_valid cycles, results and tags in order.
- Reload: load_start, then DEPTH ld_valid words with gaps every 3rd cycle -> in_ready=0 throughout; ld_done pulses once; readback matches the loaded data; in_ready=1 after.
- Simultaneous load_start with in_valid -> the lookup returns old data and LOAD is entered the next cycle.
- Reset at load word 100 -> out_valid=0, in_ready=1, no ld_done; words 0..99 hold new data, words 100 and up hold old data.
- With PHASE_LUT_SYMFOLD_EN, stored {9'h010, x} at acc=1: lookup with acc=9'h1FE -> phi_error=9'h1F0.
